// File: rtl/rr_arb_4_pkg.sv
// Shared types and constants for the 4-way round-robin arbiter.
package rr_arb_4_pkg;

  localparam int unsigned N_REQ = 4;

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

endpackage

// File: rtl/rr_arb_4_pick.sv
// rr_pick_4: combinational rotating-priority pick; first set bit of eff from ptr upward, mod 4.
module rr_pick_4
  import rr_arb_4_pkg::*;
(
  input  logic [N_REQ-1:0] eff,
  input  logic [1:0]       ptr,
  output logic [N_REQ-1:0] win,
  output logic [1:0]       idx
);

  logic       found;
  logic [1:0] pos;

  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      pos = ptr + 2'(k);
      if (!found && eff[pos]) begin
        found    = 1'b1;
        idx      = pos;
        win[pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arb_4.sv
// rr_arb_4: 4-requester round-robin arbiter with registered one-hot grant and valid/ready handshake.
// Optional request latching is enabled by defining RR_ARB_4_PEND_LATCH_EN.
module rr_arb_4
  import rr_arb_4_pkg::*;
#(
  parameter int unsigned RST_PTR = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic             gnt_vld,
  input  logic             gnt_rdy,
  output logic             busy
);

  state_t           state;
  logic [1:0]       ptr;
  logic [1:0]       idx_q;
  logic [N_REQ-1:0] eff;
  logic [N_REQ-1:0] win;
  logic [1:0]       idx;
  logic             acc;

  assign acc = gnt_vld & gnt_rdy;

`ifdef RR_ARB_4_PEND_LATCH_EN
  logic [N_REQ-1:0] pend;
  logic [N_REQ-1:0] acc_mask;

  assign acc_mask = acc ? gnt : '0;
  assign eff      = pend | req;

  // A request re-raised on the acceptance edge survives because req is OR-ed after the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend <= '0;
    else     pend <= (pend & ~acc_mask) | req;
  end
`else
  assign eff = req;
`endif

  rr_pick_4 u_pick (
    .eff (eff),
    .ptr (ptr),
    .win (win),
    .idx (idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      gnt     <= '0;
      gnt_vld <= 1'b0;
      busy    <= 1'b0;
      ptr     <= 2'(RST_PTR);
      idx_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|eff) begin
            gnt     <= win;
            gnt_vld <= 1'b1;
            busy    <= 1'b1;
            idx_q   <= idx;
            state   <= GRANT;
          end
        end
        GRANT: begin
          if (acc) begin
            gnt     <= '0;
            gnt_vld <= 1'b0;
            busy    <= 1'b0;
            ptr     <= idx_q + 2'd1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/rr_arb_4.md
RR_ARB_4 -- requirements
Module: rr_arb_4

Interface
REQ-001 SHALL have parameter RST_PTR, default 0, meaning the priority pointer value (0..3) loaded at reset.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port req  input  4  request lines; bit i = requester i.
REQ-005 SHALL have port gnt  output  4  one-hot grant; feeds the downstream 4x2 encoder's a/b/c/d inputs (bit0=a ... bit3=d).
REQ-006 SHALL have port gnt_vld  output  1  gnt holds a valid grant.
REQ-007 SHALL have port gnt_rdy  input  1  downstream accepts the grant this cycle.
REQ-008 SHALL have port busy  output  1  FSM is in state GRANT.

Function
REQ-009 SHALL implement FSM states IDLE and GRANT, registered, with all outputs driven from registers.
REQ-010 SHALL, in IDLE, form the effective request vector eff (see REQ-020/021), and when eff != 0 load gnt with the one-hot winner, set gnt_vld=1 and go to GRANT on the same edge (1-cycle latency from request to gnt_vld).
REQ-011 SHALL choose as winner the first set bit of eff scanning ptr, ptr+1, ... cyclically mod 4.
REQ-012 SHALL, in IDLE with eff == 0, keep gnt=0000 and gnt_vld=0.
REQ-013 SHALL, in GRANT with gnt_rdy=0, hold gnt and gnt_vld stable, even if req changes or drops (no retraction).
REQ-014 SHALL treat gnt_vld & gnt_rdy as acceptance: on that edge clear gnt to 0000 and gnt_vld to 0, set ptr to (winner index + 1) mod 4, and return to IDLE.
REQ-015 SHALL insert exactly one idle cycle (gnt_vld=0) between consecutive grants; no back-to-back grants.
REQ-016 SHALL ignore gnt_rdy while gnt_vld=0.
REQ-017 SHALL never assert more than one gnt bit, and SHALL keep gnt=0000 whenever gnt_vld=0.
REQ-018 SHALL hold ptr as 2 bits with natural wrap 3 -> 0.

Reset
REQ-019 SHALL, while rst=1 (asynchronously, including mid-GRANT), force state=IDLE, gnt=0000, gnt_vld=0, busy=0, ptr=RST_PTR, and clear all pending bits; the first grant SHALL be possible on the first rising edge after rst deasserts.

Configuration
REQ-020 SHALL, when macro RR_ARB_4_PEND_LATCH_EN is defined, keep a 4-bit pending register updated every cycle as pend <= (pend & ~acc_mask) | req, where acc_mask = gnt on an acceptance edge and 0000 otherwise, and use eff = pend | req; a request re-asserted on the acceptance cycle SHALL stay pending, and single-cycle request pulses SHALL therefore never be lost.
REQ-021 SHALL, when RR_ARB_4_PEND_LATCH_EN is undefined, contain no pending register and use eff = req (level-sensitive), so a request deasserted before IDLE samples it is dropped.

Structure
REQ-022 SHALL place the state enum (IDLE, GRANT) and the constant N_REQ=4 in shared package rr_arb_4_pkg.
REQ-023 SHALL put the rotating-priority pick in combinational sub-module rr_pick_4 (inputs eff[3:0] and ptr[1:0]; outputs one-hot win[3:0] and idx[1:0]).

Verification
REQ-024 SHALL cover reset-priority pick: RST_PTR=0, req=1111, gnt_rdy=1 held -> grants 0001, 0010, 0100, 1000, 0001 in order, with one gnt_vld=0 cycle between each.
REQ-025 SHALL cover backpressure: req=0100 one cycle after reset, gnt_rdy=0 for 5 cycles then 1, req dropped to 0000 after the first cycle -> gnt=0100 held for 6 cycles, then gnt_vld=0 and ptr=3.
REQ-026 SHALL cover pointer wrap: ptr=3 with req=1001 -> gnt=1000; after acceptance ptr=0 and the next grant is 0001.
REQ-027 SHALL cover the pulse request: 1-cycle req=0010 pulse while in GRANT on bit0 -> with RR_ARB_4_PEND_LATCH_EN, gnt=0010 follows acceptance plus one idle cycle; without it, no grant.
REQ-028 SHALL cover reset mid-operation: rst asserted between clock edges while gnt=0100 and gnt_vld=1 -> gnt=0000, gnt_vld=0 and busy=0 immediately, with no clock edge needed.
REQ-029 SHALL check with an end-to-end assertion that, while gnt_vld=1, gnt is one-hot and busy=1.
